// File: rtl/user_proj_io_ctrl.sv
// ============================================================================
// Module   : user_proj_io_ctrl
// Brief    : Parametrised multi-channel user-area IO controller. Each pad
//            channel is configured at run time as input, static output,
//            PWM output or rising-edge counter through a valid/ready write
//            port. Counters are read back through a registered read port.
//            Optional macro IO_IN_SYNC_EN selects a two-flop input
//            synchroniser; without it io_in must be synchronous to wb_clk_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module user_proj_io_ctrl #(
    parameter  int NUM_CH = 5,
    parameter  int PWM_W  = 8,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PWM_W-1:0]  cfg_value,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_cnt,
    input  logic [NUM_CH-1:0] io_in,
    output logic [NUM_CH-1:0] io_out,
    output logic [NUM_CH-1:0] io_oeb
);

    localparam logic [1:0]       c_mode_in  = 2'd0;
    localparam logic [1:0]       c_mode_out = 2'd1;
    localparam logic [1:0]       c_mode_pwm = 2'd2;
    localparam logic [1:0]       c_mode_cnt = 2'd3;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam int               c_rd_depth = 1 << CH_W;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_cfg_ready;
    logic [CH_W-1:0]    r_lat_ch;
    logic [1:0]         r_lat_mode;
    logic [PWM_W-1:0]   r_lat_value;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   w_cnt     [NUM_CH];
    logic [CNT_W-1:0]   w_cnt_pad [c_rd_depth];

    assign cfg_ready = r_cfg_ready;
    assign rd_cnt    = r_rd_cnt;

    // Config FSM: accept a write in IDLE, commit it to the channel in APPLY
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b0;
            r_lat_ch    <= '0;
            r_lat_mode  <= '0;
            r_lat_value <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid && r_cfg_ready) begin
                        r_lat_ch    <= cfg_ch;
                        r_lat_mode  <= cfg_mode;
                        r_lat_value <= cfg_value;
                        r_state     <= S_APPLY;
                        r_cfg_ready <= 1'b0;
                    end else begin
                        r_cfg_ready <= 1'b1;
                    end
                end
                S_APPLY: begin
                    r_state     <= S_IDLE;
                    r_cfg_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    // Shared free-running PWM period counter, wraps naturally at 2^PWM_W
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       r_mode;
        logic [PWM_W-1:0] r_val;
        logic [CNT_W-1:0] r_cnt;
        logic             r_hist;
        logic             w_level;
        logic             w_rise;
        logic             w_wr;

`ifdef IO_IN_SYNC_EN
        logic r_meta;
        logic r_sync;

        // Two-flop synchroniser followed by a history flop for edge detection
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_hist <= 1'b0;
            end else begin
                r_meta <= io_in[i];
                r_sync <= r_meta;
                r_hist <= r_sync;
            end
        end

        assign w_level = r_sync;
`else
        logic r_samp;

        // Single sample flop followed by a history flop for edge detection
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                r_samp <= 1'b0;
                r_hist <= 1'b0;
            end else begin
                r_samp <= io_in[i];
                r_hist <= r_samp;
            end
        end

        assign w_level = r_samp;
`endif

        assign w_rise = w_level & ~r_hist;
        // Out-of-range channel numbers match no channel, so they are dropped
        assign w_wr   = (r_state == S_APPLY) && (r_lat_ch == CH_W'(i));

        // Channel mode/value registers, loaded in the APPLY cycle
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                r_mode <= c_mode_in;
                r_val  <= '0;
            end else if (w_wr) begin
                r_mode <= r_lat_mode;
                r_val  <= r_lat_value;
            end
        end

        // Saturating edge counter; a config write clears it before any increment
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                r_cnt <= '0;
            end else if (w_wr) begin
                r_cnt <= '0;
            end else if (w_rise && (r_mode == c_mode_cnt) && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign io_oeb[i] = !((r_mode == c_mode_out) || (r_mode == c_mode_pwm));
        assign io_out[i] = (r_mode == c_mode_out) ? r_val[0] :
                           (r_mode == c_mode_pwm) ? (r_pwm_cnt < r_val) : 1'b0;
        assign w_cnt[i]  = r_cnt;
    end

    // Pad the counter array to the full rd_ch range so unused codes read 0
    always_comb begin
        for (int j = 0; j < c_rd_depth; j++) begin
            w_cnt_pad[j] = '0;
        end
        for (int j = 0; j < NUM_CH; j++) begin
            w_cnt_pad[j] = w_cnt[j];
        end
    end

    // Registered counter read-back, one cycle after rd_ch is presented
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rd_cnt <= '0;
        end else begin
            r_rd_cnt <= w_cnt_pad[rd_ch];
        end
    end

endmodule

`default_nettype wire
